// File: rtl/bike_round_pkg.sv
// Shared encodings, PS/2 prefix codes and default key/direction maps for the
// lightbike round controller.
package bike_round_pkg;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_R = 2'd1,
        DIR_D = 2'd2,
        DIR_L = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RUN       = 2'd2,
        ST_OVER      = 2'd3
    } state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Player p occupies [32p+:32] as {left, right, down, up}.
    localparam logic [127:0] DEFAULT_KEY_MAP = {
        32'h6b74_7375, 32'h3b4b_4243, 32'h2b33_342c, 32'h1c23_1b1d
    };

    // p0=R, p1=L, p2=D, p3=U packed two bits per player.
    localparam logic [7:0] DEFAULT_INIT_DIR = {DIR_U, DIR_D, DIR_L, DIR_R};

    function automatic logic [1:0] slotToDir(input logic [1:0] slot);
        case (slot)
            2'd0:    return DIR_U;
            2'd1:    return DIR_D;
            2'd2:    return DIR_R;
            default: return DIR_L;
        endcase
    endfunction

endpackage

// File: rtl/bike_key_decoder.sv
// PS/2 scancode decoder: swallows break sequences and matches make codes
// against the key map, giving a single-cycle {hit, player, dir}.
module bike_key_decoder
    import bike_round_pkg::*;
#(
    parameter int                        NUM_PLAYERS = 4,
    parameter logic [32*NUM_PLAYERS-1:0] KEY_MAP     = DEFAULT_KEY_MAP
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_keyStrobe,
    input  logic [7:0] i_keyData,
    output logic       o_hit,
    output logic [2:0] o_player,
    output logic [1:0] o_dir
);

    logic r_break;
    logic w_isBreak;
    logic w_isExt;

    assign w_isBreak = (i_keyData == PS2_BREAK);
    assign w_isExt   = (i_keyData == PS2_EXT);

    // An E0 prefix leaves matching unchanged, so only the break state needs
    // to persist: the byte after F0 is a release and is thrown away.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_break <= 1'b0;
        end else if (i_keyStrobe) begin
            if (r_break)
                r_break <= 1'b0;
            else if (w_isBreak)
                r_break <= 1'b1;
        end
    end

    always_comb begin
        o_hit    = 1'b0;
        o_player = '0;
        o_dir    = '0;
        if (i_keyStrobe && !r_break && !w_isBreak && !w_isExt) begin
            for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
                for (int k = 3; k >= 0; k--) begin
                    if (KEY_MAP[32*p + 8*k +: 8] == i_keyData) begin
                        o_hit    = 1'b1;
                        o_player = 3'(p);
                        o_dir    = slotToDir(2'(k));
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bike_round_ctrl.sv
// Lightbike round controller: round FSM, countdown, per-player directions,
// alive tracking and winner. BIKE_ROUND_SCORE_EN adds saturating win counters.
module bike_round_ctrl
    import bike_round_pkg::*;
#(
    parameter int                        NUM_PLAYERS = 4,
    parameter int                        START_DELAY = 50_000_000,
    parameter logic [32*NUM_PLAYERS-1:0] KEY_MAP     = DEFAULT_KEY_MAP,
    parameter logic [2*NUM_PLAYERS-1:0]  INIT_DIR    = DEFAULT_INIT_DIR,
    parameter int                        SCORE_W     = 4
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           ps2_key_pressed,
    input  logic [7:0]                     ps2_key_data,
    input  logic [NUM_PLAYERS-1:0]         player_en,
    input  logic [NUM_PLAYERS-1:0]         crash,
    input  logic                           step,
    input  logic                           start,
    output logic [2*NUM_PLAYERS-1:0]       dir,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic                           run,
    output logic                           game_over,
    output logic [3:0]                     winner,
    output logic [1:0]                     state,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score
);

    localparam int CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    state_t                   r_state, w_nextState;
    logic                     r_startQ, r_startPrev;
    logic [CNT_W-1:0]         r_count;
    logic [NUM_PLAYERS-1:0]   r_enabled, r_alive, r_pendValid;
    logic [2*NUM_PLAYERS-1:0] r_dir, r_pendDir;
    logic                     r_gameOver;
    logic [3:0]               r_winner;

    logic                     w_startEdge, w_launch, w_roundEnd, w_keyAccept;
    logic                     w_keyHit;
    logic [2:0]               w_keyPlayer;
    logic [1:0]               w_keyDir;
    logic [NUM_PLAYERS-1:0]   w_aliveNext;
    logic [3:0]               w_enCount, w_aliveCount, w_winner;

    bike_key_decoder #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .KEY_MAP     (KEY_MAP)
    ) u_decoder (
        .clock       (clock),
        .resetn      (resetn),
        .i_keyStrobe (ps2_key_pressed),
        .i_keyData   (ps2_key_data),
        .o_hit       (w_keyHit),
        .o_player    (w_keyPlayer),
        .o_dir       (w_keyDir)
    );

    assign w_startEdge = r_startQ & ~r_startPrev;
    assign w_launch    = w_startEdge && (|player_en) &&
                         (r_state == ST_IDLE || r_state == ST_OVER);
    assign w_aliveNext = r_alive & ~crash;

    // With only one enabled player the round runs until that player dies.
    always_comb begin
        w_enCount    = '0;
        w_aliveCount = '0;
        w_winner     = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_enCount    = w_enCount + 4'(r_enabled[p]);
            w_aliveCount = w_aliveCount + 4'(w_aliveNext[p]);
            if (w_aliveNext[p])
                w_winner = 4'(p + 1);
        end
        w_roundEnd = ((w_enCount >= 4'd2) && (w_aliveCount <= 4'd1)) ||
                     ((w_enCount == 4'd1) && (w_aliveCount == 4'd0));
    end

    // Keys are validated against the committed direction, never the pending one.
    always_comb begin
        w_keyAccept = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_keyHit && r_state == ST_RUN && w_keyPlayer == 3'(p) && r_alive[p] &&
                (w_keyDir != (r_dir[2*p +: 2] ^ 2'b10)))
                w_keyAccept = 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:      if (w_launch) w_nextState = ST_COUNTDOWN;
            ST_COUNTDOWN: if (r_count == '0) w_nextState = ST_RUN;
            ST_RUN:       if (w_roundEnd) w_nextState = ST_OVER;
            ST_OVER:      if (w_launch) w_nextState = ST_COUNTDOWN;
            default:      w_nextState = ST_IDLE;
        endcase
    end

    // A step commits pending moves first, so a key arriving with the step
    // is kept for the following step.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_startQ    <= 1'b0;
            r_startPrev <= 1'b0;
            r_count     <= '0;
            r_enabled   <= '0;
            r_alive     <= '0;
            r_dir       <= INIT_DIR;
            r_pendValid <= '0;
            r_pendDir   <= '0;
            r_gameOver  <= 1'b0;
            r_winner    <= '0;
        end else begin
            r_state     <= w_nextState;
            r_startQ    <= start;
            r_startPrev <= r_startQ;
            r_gameOver  <= 1'b0;
            if (w_launch) begin
                r_count     <= CNT_W'(START_DELAY - 1);
                r_enabled   <= player_en;
                r_alive     <= player_en;
                r_dir       <= INIT_DIR;
                r_pendValid <= '0;
                r_pendDir   <= '0;
                r_winner    <= '0;
            end else if (r_state == ST_COUNTDOWN) begin
                if (r_count != '0)
                    r_count <= r_count - 1'b1;
            end else if (r_state == ST_RUN) begin
                r_alive <= w_aliveNext;
                if (w_roundEnd) begin
                    r_gameOver <= 1'b1;
                    r_winner   <= w_winner;
                end
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (step) begin
                        r_pendValid[p] <= 1'b0;
                        if (r_alive[p] && r_pendValid[p])
                            r_dir[2*p +: 2] <= r_pendDir[2*p +: 2];
                    end
                    if (w_keyAccept && w_keyPlayer == 3'(p)) begin
                        r_pendValid[p]      <= 1'b1;
                        r_pendDir[2*p +: 2] <= w_keyDir;
                    end
                end
            end
        end
    end

`ifdef BIKE_ROUND_SCORE_EN
    logic [NUM_PLAYERS*SCORE_W-1:0] r_score;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_score <= '0;
        end else if (r_state == ST_RUN && w_roundEnd) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (w_winner == 4'(p + 1) && r_score[p*SCORE_W +: SCORE_W] != '1)
                    r_score[p*SCORE_W +: SCORE_W] <= r_score[p*SCORE_W +: SCORE_W] + 1'b1;
            end
        end
    end

    assign score = r_score;
`else
    assign score = '0;
`endif

    assign state     = r_state;
    assign run       = (r_state == ST_RUN);
    assign game_over = r_gameOver;
    assign winner    = r_winner;
    assign dir       = r_dir;
    assign alive     = r_alive;

endmodule
